// File: rtl/perf_ctr_pkg.sv
// ============================================================================
// perf_ctr_pkg : shared types, CTRL bit indices and register-offset helpers
// Revision     : 1.0
// ============================================================================
`default_nettype none

package perf_ctr_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } perf_state_t;

  localparam int CLR_ALL_BIT = 0;
  localparam int FREEZE_BIT  = 1;

  // Offsets are 5 bits wide so that NUM_CTRS=16 pushes CTRL/OVF out of the
  // 16-word window instead of aliasing onto counter 0/1.
  function automatic logic [4:0] ctrl_ofs(input int num_ctrs);
    return 5'(num_ctrs);
  endfunction

  function automatic logic [4:0] ovf_ofs(input int num_ctrs);
    return 5'(num_ctrs + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/perf_ctr_slice.sv
// ============================================================================
// perf_ctr_slice : one event counter with clear, byte-merged write, freeze
// Revision       : 1.0
// ============================================================================
`default_nettype none

module perf_ctr_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             wr_en_i,
  input  logic [31:0]      wr_data_i,
  input  logic [3:0]       byte_en_i,
  input  logic             freeze_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [31:0]      merged_d;

  always_comb begin
    merged_d = 32'(count_q);
    for (int b = 0; b < 4; b++) begin
      if (byte_en_i[b]) merged_d[8*b +: 8] = wr_data_i[8*b +: 8];
    end
  end

  // A write or clear on the same edge as an increment swallows the increment.
  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (wr_en_i) begin
      count_d = merged_d[WIDTH-1:0];
    end else if (!freeze_i && inc_i) begin
      count_d = count_q + WIDTH'(1);
      wrap_o  = &count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/perf_ctr_bank.sv
// ============================================================================
// perf_ctr_bank : memory-mapped bank of event counters with CTRL register;
//                 PERF_CTR_OVF_EN adds sticky per-counter overflow + ovf_any
// Revision      : 1.0
// ============================================================================
`default_nettype none

module perf_ctr_bank #(
  parameter int          NUM_CTRS  = 8,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CTRS-1:0] inc,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         mem_address,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_byte_enable,
  output logic                hit,
  output logic [31:0]         mem_rdata,
  output logic                mem_resp
`ifdef PERF_CTR_OVF_EN
  ,
  output logic                ovf_any
`endif
);

  import perf_ctr_pkg::*;

  localparam logic [4:0] CTRL_OFS = ctrl_ofs(NUM_CTRS);
  localparam logic [4:0] OVF_OFS  = ovf_ofs(NUM_CTRS);

  perf_state_t         state_q, state_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                freeze_q, freeze_d;
  logic [WIDTH-1:0]    cnt_w [NUM_CTRS];
  logic [NUM_CTRS-1:0] wr_sel_w, wrap_w;
  logic [4:0]          ofs_w;
  logic [31:0]         rd_val_w;
  logic                accept_w, wr_w, rd_w, ctrl_wr_w, clr_all_w;
  logic                unused_w;

  assign hit       = (mem_address[31:6] == BASE_ADDR[31:6]);
  assign ofs_w     = {1'b0, mem_address[5:2]};
  assign accept_w  = (state_q == IDLE) && hit && (mem_read || mem_write);
  assign wr_w      = accept_w && mem_write;
  assign rd_w      = accept_w && !mem_write;
  assign ctrl_wr_w = wr_w && (ofs_w == CTRL_OFS) && mem_byte_enable[0];
  assign clr_all_w = ctrl_wr_w && mem_wdata[CLR_ALL_BIT];

  generate
    for (genvar i = 0; i < NUM_CTRS; i++) begin : g_ctr
      assign wr_sel_w[i] = wr_w && (ofs_w == 5'(i));
      perf_ctr_slice #(.WIDTH(WIDTH)) u_slice (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_all_w),
        .wr_en_i   (wr_sel_w[i]),
        .wr_data_i (mem_wdata),
        .byte_en_i (mem_byte_enable),
        .freeze_i  (freeze_q),
        .inc_i     (inc[i]),
        .count_o   (cnt_w[i]),
        .wrap_o    (wrap_w[i])
      );
    end
  endgenerate

`ifdef PERF_CTR_OVF_EN
  logic [NUM_CTRS-1:0] ovf_q, ovf_d;
  logic                ovf_any_q;

  // Wrap is OR-ed in after the W1C so a same-cycle set wins over the clear.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_all_w) begin
      ovf_d = '0;
    end else begin
      if (wr_w && (ofs_w == OVF_OFS)) begin
        for (int i = 0; i < NUM_CTRS; i++) begin
          if (mem_wdata[i] && mem_byte_enable[i/8]) ovf_d[i] = 1'b0;
        end
      end
      ovf_d = ovf_d | wrap_w;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q     <= '0;
      ovf_any_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      ovf_any_q <= |ovf_d;
    end
  end

  assign ovf_any  = ovf_any_q;
  assign unused_w = ^mem_address[1:0];
`else
  assign unused_w = ^{mem_address[1:0], wrap_w};
`endif

  always_comb begin
    rd_val_w = '0;
    for (int i = 0; i < NUM_CTRS; i++) begin
      if (ofs_w == 5'(i)) rd_val_w = 32'(cnt_w[i]);
    end
    if (ofs_w == CTRL_OFS) rd_val_w[FREEZE_BIT] = freeze_q;
`ifdef PERF_CTR_OVF_EN
    if (ofs_w == OVF_OFS) rd_val_w = 32'(ovf_q);
`endif
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    freeze_d = freeze_q;
    mem_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_w) begin
          state_d = RESP;
          rdata_d = rd_w ? rd_val_w : 32'h0;
        end
      end
      RESP: begin
        mem_resp = 1'b1;
        state_d  = IDLE;
        rdata_d  = 32'h0;
      end
    endcase
    if (ctrl_wr_w) freeze_d = mem_wdata[FREEZE_BIT];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rdata_q  <= 32'h0;
      freeze_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      freeze_q <= freeze_d;
    end
  end

  assign mem_rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_perf_ctr_bank.sv
// ============================================================================
// tb_perf_ctr_bank : directed scoreboard bench for perf_ctr_bank
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_perf_ctr_bank;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  inc = 8'h0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_byte_enable = 4'h0;
  logic        hit;
  logic [31:0] mem_rdata;
  logic        mem_resp;
`ifdef PERF_CTR_OVF_EN
  logic        ovf_any;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  req_inc = 8'h0;

  perf_ctr_bank dut (
    .clk             (clk),
    .rst             (rst),
    .inc             (inc),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .hit             (hit),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
`ifdef PERF_CTR_OVF_EN
    ,
    .ovf_any         (ovf_any)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Request presented after a negedge in IDLE; response must be visible right
  // after the next posedge. Returns one cycle later so the next call lands in
  // the cycle after RESP.
  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    mem_address = addr;
    mem_read    = 1'b1;
    inc         = req_inc;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    inc = 8'h0;
    chk({tag, "_resp"}, 32'(mem_resp), 32'h1);
    chk(tag, mem_rdata, exp_q.pop_front());
    mem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                    input string tag);
    @(negedge clk);
    mem_address     = addr;
    mem_wdata       = data;
    mem_byte_enable = be;
    mem_write       = 1'b1;
    inc             = req_inc;
    @(posedge clk); #1;
    inc = 8'h0;
    chk({tag, "_resp"}, 32'(mem_resp), 32'h1);
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_inc(input logic [7:0] mask, input int n);
    @(negedge clk);
    inc = mask;
    repeat (n) @(negedge clk);
    inc = 8'h0;
  endtask

  initial begin
    bit seen;

    repeat (2) @(posedge clk); #1;
    chk("rst_resp", 32'(mem_resp), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
`ifdef PERF_CTR_OVF_EN
    chk("rst_ovf_any", 32'(ovf_any), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    pulse_inc(8'h01, 5);
    rd(BASE, 32'd5, "ctr0_five");
    for (int i = 1; i < 8; i++) rd(BASE + 32'(4 * i), 32'h0, $sformatf("ctr%0d_zero", i));

    wr(BASE + 32'h08, 32'hFFFF_FFFE, 4'hF, "wr_ctr2");
    pulse_inc(8'h04, 3);
    rd(BASE + 32'h08, 32'h0000_0001, "ctr2_wrap");
`ifdef PERF_CTR_OVF_EN
    rd(BASE + 32'h24, 32'h4, "ovf_bit2");
    chk("ovf_any_set", 32'(ovf_any), 32'h1);
    wr(BASE + 32'h24, 32'h4, 4'hF, "ovf_w1c");
    rd(BASE + 32'h24, 32'h0, "ovf_cleared");
    chk("ovf_any_clr", 32'(ovf_any), 32'h0);
`else
    rd(BASE + 32'h24, 32'h0, "ofs9_unmapped");
`endif

    pulse_inc(8'h02, 3);
    rd(BASE + 32'h04, 32'd3, "ctr1_three");
    wr(BASE + 32'h20, 32'h2, 4'hF, "freeze_on");
    pulse_inc(8'h02, 10);
    rd(BASE + 32'h04, 32'd3, "ctr1_frozen");
    rd(BASE + 32'h20, 32'h2, "ctrl_freeze_rd");
    wr(BASE + 32'h20, 32'h1, 4'hF, "clr_all");
    rd(BASE,          32'h0, "ctr0_cleared");
    rd(BASE + 32'h04, 32'h0, "ctr1_cleared");
    rd(BASE + 32'h08, 32'h0, "ctr2_cleared");
    rd(BASE + 32'h20, 32'h0, "ctrl_after_clr");
    pulse_inc(8'h02, 2);
    rd(BASE + 32'h04, 32'd2, "ctr1_unfrozen");

    wr(BASE + 32'h0C, 32'h1234_5678, 4'hF, "wr_ctr3");
    wr(BASE + 32'h0C, 32'h0000_AB00, 4'b0010, "wr_ctr3_byte1");
    rd(BASE + 32'h0C, 32'h1234_AB78, "ctr3_merged");

    // Increment coincident with a write to the same counter is dropped.
    req_inc = 8'h08;
    wr(BASE + 32'h0C, 32'h10, 4'hF, "wr_ctr3_inc");
    req_inc = 8'h00;
    rd(BASE + 32'h0C, 32'h10, "ctr3_inc_lost");

    // Increment on the accepting edge of a read is not visible in that read.
    req_inc = 8'h10;
    rd(BASE + 32'h10, 32'h0, "ctr4_pre_inc");
    req_inc = 8'h00;
    rd(BASE + 32'h10, 32'h1, "ctr4_post_inc");

    rd(BASE + 32'h3C, 32'h0, "ofs15_unmapped");
    @(negedge clk);
    mem_address = BASE + 32'h3C;
    #1 chk("hit_in_window", 32'(hit), 32'h1);

    @(negedge clk);
    mem_address = BASE + 32'h40;
    mem_read    = 1'b1;
    #1 chk("hit_outside", 32'(hit), 32'h0);
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (mem_resp) seen = 1'b1;
    end
    chk("miss_no_resp", 32'(seen), 32'h0);
    mem_read = 1'b0;

    pulse_inc(8'h01, 4);
    @(negedge clk);
    mem_address = BASE;
    mem_read    = 1'b1;
    exp_q.push_back(32'd4);
    @(posedge clk); #1;
    chk("pre_rst_resp", 32'(mem_resp), 32'h1);
    chk("pre_rst_rdata", mem_rdata, exp_q.pop_front());
    mem_read = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_resp", 32'(mem_resp), 32'h0);
    chk("mid_rst_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rd(BASE,          32'h0, "ctr0_post_rst");
    rd(BASE + 32'h0C, 32'h0, "ctr3_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
